// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported memory between an instruction-fetch port and a
// load/store port. At most one access is issued per cycle. Load/store normally
// wins, but a fetch that has been denied STARVE_MAX cycles in a row is
// force-granted. Read data returns exactly one cycle after issue and is routed
// back to whichever port issued the read.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   if_req_i/if_addr_i    fetch read request and address
//   if_stall_o            fetch request present but not accepted this cycle
//   if_rvalid_o/if_rdata_o fetch read response
//   ls_req_i/ls_write_i   load/store request, 1 = store
//   ls_addr_i/ls_wdata_i  load/store address and store data
//   ls_stall_o            load/store request present but not accepted
//   ls_rvalid_o/ls_rdata_o load response (stores give no response)
//   mem_en_o/mem_we_o     memory access strobe and write strobe
//   mem_addr_o/mem_wdata_o memory address and write data
//   mem_rdata_i           memory read data, valid one cycle after a read issue
//   dbg_state             current response-FSM state (debug observation)
//
// Handshake: a requester raises req and keeps req/addr/data stable until a
// cycle in which req=1 and stall=0; the rising edge ending that cycle is the
// acceptance. A read response is a single-cycle rvalid pulse in the next cycle,
// with no back-pressure on the response side.

module mem_arbiter #(
    parameter int ADDR       = 32,
    parameter int W_OPR      = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req_i,
    input  logic [ADDR-1:0]  if_addr_i,
    output logic             if_stall_o,
    output logic             if_rvalid_o,
    output logic [W_OPR-1:0] if_rdata_o,
    input  logic             ls_req_i,
    input  logic             ls_write_i,
    input  logic [ADDR-1:0]  ls_addr_i,
    input  logic [W_OPR-1:0] ls_wdata_i,
    output logic             ls_stall_o,
    output logic             ls_rvalid_o,
    output logic [W_OPR-1:0] ls_rdata_o,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [ADDR-1:0]  mem_addr_o,
    output logic [W_OPR-1:0] mem_wdata_o,
    input  logic [W_OPR-1:0] mem_rdata_i,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_LS = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state, state_nxt;
    logic [3:0] starve_q, starve_nxt;
    logic       force_if;
    logic       grant_if;
    logic       grant_ls;

    // Grant decision. Qualifying with reset keeps every memory-side output and
    // both stalls at zero while reset is asserted, with no flop in the path.
    always_comb begin
        force_if = if_req_i && (starve_q == STARVE_LIM);
        grant_if = reset && if_req_i && (!ls_req_i || force_if);
        grant_ls = reset && ls_req_i && !grant_if;
    end

    // Starve counter: counts consecutive cycles a fetch request was denied.
    always_comb begin
        starve_nxt = starve_q;
        if (!if_req_i || grant_if) begin
            starve_nxt = 4'd0;
        end else if (starve_q != STARVE_LIM) begin
            starve_nxt = starve_q + 4'd1;
        end
    end

    // Response FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state    <= state_nxt;
            starve_q <= starve_nxt;
        end
    end

    // Response FSM: next state. It records only who owns the read data that
    // arrives next cycle, so a new grant can overlap the current response.
    always_comb begin
        state_nxt = IDLE;
        if (grant_if) begin
            state_nxt = RESP_IF;
        end else if (grant_ls && !ls_write_i) begin
            state_nxt = RESP_LS;
        end
    end

    // Response FSM: outputs.
    always_comb begin
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        ls_rvalid_o = 1'b0;
        ls_rdata_o  = '0;
        case (state)
            RESP_IF: begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = mem_rdata_i;
            end
            RESP_LS: begin
                ls_rvalid_o = 1'b1;
                ls_rdata_o  = mem_rdata_i;
            end
            default: ;
        endcase
    end

    // Memory-side request path and stalls.
    always_comb begin
        mem_en_o    = grant_if || grant_ls;
        mem_we_o    = grant_ls && ls_write_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (grant_if) begin
            mem_addr_o = if_addr_i;
        end else if (grant_ls) begin
            mem_addr_o  = ls_addr_i;
            mem_wdata_o = ls_wdata_i;
        end
        if_stall_o = reset && if_req_i && !grant_if;
        ls_stall_o = reset && ls_req_i && !grant_ls;
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed steps followed by a randomized phase. A small memory model answers
// the DUT's memory port; a behavioural reference (consecutive-denial count,
// shadow memory, last-cycle response) predicts every output each cycle.

module tb_mem_arbiter;

    localparam int ADDR       = 32;
    localparam int W_OPR      = 32;
    localparam int STARVE_MAX = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             if_req_i = 1'b0;
    logic [ADDR-1:0]  if_addr_i = '0;
    logic             if_stall_o;
    logic             if_rvalid_o;
    logic [W_OPR-1:0] if_rdata_o;
    logic             ls_req_i = 1'b0;
    logic             ls_write_i = 1'b0;
    logic [ADDR-1:0]  ls_addr_i = '0;
    logic [W_OPR-1:0] ls_wdata_i = '0;
    logic             ls_stall_o;
    logic             ls_rvalid_o;
    logic [W_OPR-1:0] ls_rdata_o;
    logic             mem_en_o;
    logic             mem_we_o;
    logic [ADDR-1:0]  mem_addr_o;
    logic [W_OPR-1:0] mem_wdata_o;
    logic [W_OPR-1:0] mem_rdata_i;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR(ADDR), .W_OPR(W_OPR), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_stall_o(if_stall_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_write_i(ls_write_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_stall_o(ls_stall_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .dbg_state(dbg_state)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i * 7);
    endfunction

    // Memory environment: 256 words indexed by the low address byte; read data
    // appears the cycle after issue, junk otherwise.
    logic [31:0] env_mem [0:255];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
            mem_rdata_i <= $urandom();
        end else begin
            if (mem_en_o && mem_we_o) env_mem[mem_addr_o[7:0]] <= mem_wdata_o;
            if (mem_en_o && !mem_we_o) mem_rdata_i <= env_mem[mem_addr_o[7:0]];
            else mem_rdata_i <= $urandom();
        end
    end

    // Reference model state
    int          compared = 0;
    int          mismatched = 0;
    int          denied_run = 0;
    logic        prev_if = 1'b0;
    logic        prev_ls = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] ref_mem [0:255];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        denied_run = 0;
        prev_if    = 1'b0;
        prev_ls    = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    endtask

    // One cycle: drive requests after the falling edge, check every output,
    // then advance the reference model to account for the coming rising edge.
    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic lr, input logic lw,
                        input logic [31:0] la, input logic [31:0] ld,
                        output logic g_if, output logic g_ls);
        logic gi, gl;
        @(negedge clk);
        reset      = 1'b1;
        if_req_i   = ir;
        if_addr_i  = ia;
        ls_req_i   = lr;
        ls_write_i = lw;
        ls_addr_i  = la;
        ls_wdata_i = ld;
        #1;
        // Fetch wins if alone, or once it has been passed over STARVE_MAX times.
        gi = ir && (!lr || denied_run >= STARVE_MAX);
        gl = lr && !gi;
        chk("if_stall", if_stall_o, ir && !gi);
        chk("ls_stall", ls_stall_o, lr && !gl);
        chk("mem_en", mem_en_o, gi || gl);
        chk("mem_we", mem_we_o, gl && lw);
        chk("mem_addr", mem_addr_o, gi ? ia : (gl ? la : 32'd0));
        chk("mem_wdata", mem_wdata_o, gl ? ld : 32'd0);
        chk("if_rvalid", if_rvalid_o, prev_if);
        chk("if_rdata", if_rdata_o, prev_if ? prev_data : 32'd0);
        chk("ls_rvalid", ls_rvalid_o, prev_ls);
        chk("ls_rdata", ls_rdata_o, prev_ls ? prev_data : 32'd0);
        chk("both_rvalid", if_rvalid_o && ls_rvalid_o, 1'b0);
        denied_run = (ir && !gi) ? denied_run + 1 : 0;
        prev_if    = gi;
        prev_ls    = gl && !lw;
        prev_data  = gi ? ref_mem[ia[7:0]] : ref_mem[la[7:0]];
        if (gl && lw) ref_mem[la[7:0]] = ld;
        g_if = gi;
        g_ls = gl;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_if_stall"}, if_stall_o, 1'b0);
        chk({tag, "_ls_stall"}, ls_stall_o, 1'b0);
        chk({tag, "_if_rvalid"}, if_rvalid_o, 1'b0);
        chk({tag, "_ls_rvalid"}, ls_rvalid_o, 1'b0);
        chk({tag, "_if_rdata"}, if_rdata_o, 32'd0);
        chk({tag, "_ls_rdata"}, ls_rdata_o, 32'd0);
        chk({tag, "_mem_en"}, mem_en_o, 1'b0);
        chk({tag, "_mem_we"}, mem_we_o, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    endtask

    logic        gi, gl;
    logic        h_ir, h_lr, h_lw;
    logic [31:0] h_ia, h_la, h_ld;

    initial begin
        // Reset with both requests asserted: everything must read zero.
        model_reset();
        if_req_i  = 1'b1;
        ls_req_i  = 1'b1;
        if_addr_i = 32'h44;
        ls_addr_i = 32'h88;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        chk("reset_state", dbg_state, 2'd0);

        // Fetch alone at 0x10, granted in the first cycle after release.
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);

        // Both request, load 0x200 wins; next cycle only ls_rvalid.
        step(1'b1, 32'h20, 1'b1, 1'b0, 32'h200, 32'h0, gi, gl);
        step(1'b0, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);

        // Continuous loads with a waiting fetch: fetch forced in on cycle 4.
        for (int i = 0; i < 6; i++)
            step(1'b1, 32'h30, 1'b1, 1'b0, 32'h100 + 32'(i), 32'h0, gi, gl);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);

        // Store 0x5A5A to 0x40, then load it back.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h5A5A, gi, gl);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, gi, gl);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);

        // Alternating fetch / load every cycle.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);
            else            step(1'b0, 32'h0, 1'b1, 1'b0, 32'h60 + 32'(i), 32'h0, gi, gl);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);

        // Fetch issued, then reset before the response cycle ends.
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        ls_req_i = 1'b1;
        #1;
        check_all_zero("pending_reset");
        chk("pending_reset_state", dbg_state, 2'd0);
        @(posedge clk);
        model_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);

        // Randomized traffic; a stalled requester holds its request.
        h_ir = 1'b0; h_lr = 1'b0; h_lw = 1'b0;
        h_ia = '0;   h_la = '0;   h_ld = '0;
        gi = 1'b0;   gl = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!h_ir || gi) begin
                h_ir = ($urandom_range(0, 3) != 0);
                h_ia = $urandom();
            end
            if (!h_lr || gl) begin
                h_lr = ($urandom_range(0, 2) != 0);
                h_lw = ($urandom_range(0, 2) == 0);
                h_la = {24'h0, 8'($urandom_range(0, 15))};
                h_ld = $urandom();
            end
            step(h_ir, h_ia, h_lr, h_lw, h_la, h_ld, gi, gl);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gl);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR, default 32: address width.
REQ-002 Parameter W_OPR, default 32: data width.
REQ-003 Parameter STARVE_MAX, default 3: consecutive denied fetch cycles before fetch is force-granted; legal range 1..15.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 if_req_i  input  1  fetch read request.
REQ-007 if_addr_i  input  ADDR  fetch address.
REQ-008 if_stall_o  output  1  fetch request not accepted this cycle.
REQ-009 if_rvalid_o  output  1  fetch read data valid.
REQ-010 if_rdata_o  output  W_OPR  fetch read data.
REQ-011 ls_req_i  input  1  load/store request.
REQ-012 ls_write_i  input  1  1 = store, 0 = load.
REQ-013 ls_addr_i  input  ADDR  load/store address.
REQ-014 ls_wdata_i  input  W_OPR  store data.
REQ-015 ls_stall_o  output  1  load/store request not accepted this cycle.
REQ-016 ls_rvalid_o  output  1  load data valid.
REQ-017 ls_rdata_o  output  W_OPR  load data.
REQ-018 mem_en_o  output  1  memory access issued this cycle.
REQ-019 mem_we_o  output  1  memory write strobe.
REQ-020 mem_addr_o  output  ADDR  memory address.
REQ-021 mem_wdata_o  output  W_OPR  memory write data.
REQ-022 mem_rdata_i  input  W_OPR  memory read data, valid exactly one cycle after a read issue.

Function
REQ-023 At most one memory access per cycle; grant decision combinational from current requests and registered starve counter.
REQ-024 Priority: ls over fetch, except fetch wins when if_req_i=1 and starve counter == STARVE_MAX.
REQ-025 Granted requester: stall_o=0, mem_en_o=1, mem_addr_o/mem_we_o/mem_wdata_o driven from its inputs (fetch: mem_we_o=0).
REQ-026 Requester with req=1 but not granted: stall_o=1; it holds its request until accepted.
REQ-027 No request: mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, both stall_o=0.
REQ-028 Starve counter (4 bits): increments when if_req_i=1 and fetch not granted; clears when fetch granted or if_req_i=0; saturates at STARVE_MAX.
REQ-029 Response FSM states IDLE, RESP_IF, RESP_LS; next state RESP_IF after fetch read issue, RESP_LS after load issue, IDLE otherwise (including store issue).
REQ-030 In RESP_IF: if_rvalid_o=1, if_rdata_o=mem_rdata_i; in RESP_LS: ls_rvalid_o=1, ls_rdata_o=mem_rdata_i; rdata outputs 0 when corresponding rvalid=0.
REQ-031 Read latency: request accepted in cycle N, rvalid in cycle N+1; back-to-back accepted reads yield rvalid every cycle.
REQ-032 Stores produce no rvalid; store followed by load to same address next cycle returns stored data (memory ordering preserved by single issue).
REQ-033 Simultaneous response and new grant allowed in same cycle; response of previous access unaffected by current grant.
REQ-034 Both rvalid outputs never asserted in same cycle.

Reset
REQ-035 reset=0 asynchronously forces FSM to IDLE, starve counter to 0; all outputs 0 while reset=0 (stalls included).
REQ-036 Reset during pending read discards it: no rvalid after reset release.
REQ-037 First grant possible in first rising edge-cycle after reset=1.

Verification
REQ-038 Fetch only, if_addr_i=0x10 -> mem_en_o=1, mem_addr_o=0x10, if_stall_o=0; next cycle if_rvalid_o=1, if_rdata_o=mem_rdata_i.
REQ-039 Both request, ls load 0x200, starve=0 -> ls granted, if_stall_o=1, starve=1; next cycle ls_rvalid_o=1, if_rvalid_o=0.
REQ-040 Continuous ls requests plus fetch, STARVE_MAX=3 -> ls granted 3 cycles, fetch granted cycle 4, counter cleared, ls_stall_o=1 that cycle.
REQ-041 Store 0x5A5A to 0x40 then load 0x40 -> mem_we_o=1 cycle N, no rvalid N+1, ls_rvalid_o=1 with 0x5A5A at N+2.
REQ-042 Fetch read issued, reset=0 asserted before next edge -> if_rvalid_o stays 0, all outputs 0, FSM IDLE after release.
REQ-043 Alternating fetch/load reads every cycle -> rvalid alternates if_/ls_ each cycle, never both high.
